ex_stage: RTL and testbench

Parametrised execution stage for the veriRISCV core: single-cycle ALU path plus an iterative RV32M multiply/divide unit. Sits between the ID/EX and EX/MEM pipeline registers. Applies MEM/WB operand forwarding and sign-extends the immediate. Stalls the front end while a multi-cycle mul/div operation runs.

---
 rtl/ex_stage.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ex_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the veriRISCV core.
// Operand forwarding from MEM/WB, immediate sign-extension and a single-cycle ALU.
// The iterative RV32M multiply/divide unit is built only when VERIRISCV_MULDIV_EN
// is defined. Without it, M-extension ops come back as illegal instructions.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int IMM_WIDTH = 20,
  parameter int RF_AW     = 5,
  parameter int ALU_OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id2ex_reg_wen,
  input  logic [RF_AW-1:0]     id2ex_reg_waddr,
  input  logic [XLEN-1:0]      id2ex_reg_rs1_data,
  input  logic [XLEN-1:0]      id2ex_reg_rs2_data,
  input  logic [IMM_WIDTH-1:0] id2ex_imm_value,
  input  logic [ALU_OP_W-1:0]  id2ex_alu_op,
  input  logic                 id2ex_sel_imm,
  input  logic                 id2ex_rs1_forward_from_mem,
  input  logic                 id2ex_rs1_forward_from_wb,
  input  logic                 id2ex_rs2_forward_from_mem,
  input  logic                 id2ex_rs2_forward_from_wb,
  input  logic                 id2ex_ill_instr,
  input  logic                 id2ex_md_req,
  input  logic [2:0]           id2ex_md_op,
  input  logic [XLEN-1:0]      wb_reg_wdata,
  input  logic                 ex_flush,
  output logic                 ex_stall,
  output logic                 ex2mem_reg_wen,
  output logic [RF_AW-1:0]     ex2mem_reg_waddr,
  output logic [XLEN-1:0]      ex2mem_alu_out,
  output logic                 ex2mem_ill_instr
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(9);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;

  // Operand selection: MEM forwarding beats WB forwarding beats the register file
  always_comb begin
    if (id2ex_rs1_forward_from_mem) rs1_fwd = ex2mem_alu_out;
    else if (id2ex_rs1_forward_from_wb) rs1_fwd = wb_reg_wdata;
    else rs1_fwd = id2ex_reg_rs1_data;
    if (id2ex_rs2_forward_from_mem) rs2_fwd = ex2mem_alu_out;
    else if (id2ex_rs2_forward_from_wb) rs2_fwd = wb_reg_wdata;
    else rs2_fwd = id2ex_reg_rs2_data;
    imm_sext = {{(XLEN-IMM_WIDTH){id2ex_imm_value[IMM_WIDTH-1]}}, id2ex_imm_value};
    if (id2ex_sel_imm) op1 = imm_sext;
    else op1 = rs2_fwd;
  end

  assign shamt = op1[SHW-1:0];

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (id2ex_alu_op)
      ALU_ADD:  alu_res = rs1_fwd + op1;
      ALU_SUB:  alu_res = rs1_fwd - op1;
      ALU_SLL:  alu_res = rs1_fwd << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_fwd) < $signed(op1))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_fwd < op1)};
      ALU_XOR:  alu_res = rs1_fwd ^ op1;
      ALU_SRL:  alu_res = rs1_fwd >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(rs1_fwd) >>> shamt);
      ALU_OR:   alu_res = rs1_fwd | op1;
      ALU_AND:  alu_res = rs1_fwd & op1;
      default:  alu_res = '0;
    endcase
  end

`ifdef VERIRISCV_MULDIV_EN
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  md_state_e         state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  // acc: {partial product high, multiplier} or {partial remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   md_result;

  // Operand signs and magnitudes for the op being issued
  always_comb begin
    a_neg = rs1_fwd[XLEN-1] & ((id2ex_md_op == MD_MULH) | (id2ex_md_op == MD_MULHSU) |
                               (id2ex_md_op == MD_DIV)  | (id2ex_md_op == MD_REM));
    b_neg = rs2_fwd[XLEN-1] & ((id2ex_md_op == MD_MULH) | (id2ex_md_op == MD_DIV) |
                               (id2ex_md_op == MD_REM));
    if (a_neg) abs_a = -rs1_fwd;
    else abs_a = rs1_fwd;
    if (b_neg) abs_b = -rs2_fwd;
    else abs_b = rs2_fwd;
  end

  // One iteration of shift-add multiply and restoring divide on the magnitudes
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    if (!div_diff[XLEN]) div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else div_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
  end

  // MD FSM next state: accept in IDLE, XLEN iterations in BUSY, result in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    if (ex_flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (id2ex_md_req) begin
            state_d = MD_BUSY;
            cnt_d   = SHW'(XLEN-1);
            op_d    = id2ex_md_op;
            acc_d   = {{XLEN{1'b0}}, abs_a};
            mcand_d = abs_b;
            dvd_d   = rs1_fwd;
            // remainder takes the dividend's sign, everything else the xor
            if ((id2ex_md_op == MD_REM) || (id2ex_md_op == MD_REMU)) neg_d = a_neg;
            else neg_d = a_neg ^ b_neg;
            div0_d  = id2ex_md_op[2] & (rs2_fwd == '0);
            ovf_d   = (id2ex_md_op == MD_DIV || id2ex_md_op == MD_REM) &
                      (rs1_fwd == MOST_NEG) & (rs2_fwd == '1);
          end else begin
            state_d = MD_IDLE;
          end
        end
        MD_BUSY: begin
          if (op_q[2]) acc_d = div_step;
          else acc_d = mul_step;
          if (cnt_q == '0) state_d = MD_DONE;
          else cnt_d = cnt_q - SHW'(1);
        end
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // MD state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      dvd_q   <= '0;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      dvd_q   <= dvd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  // Sign fix-up and special-case override of the finished result
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       md_result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              md_result = div0_q ? '1 : (ovf_q ? dvd_q : quo_fix);
      MD_REM, MD_REMU:              md_result = div0_q ? dvd_q : (ovf_q ? '0 : rem_fix);
      default:                      md_result = '0;
    endcase
  end

  assign ex_stall = rst_n & id2ex_md_req & (state_q != MD_DONE) & ~ex_flush;
`else
  logic unused_md_op;
  assign unused_md_op = ^id2ex_md_op;
  assign ex_stall     = 1'b0;
`endif

  // EX/MEM register: bubble on stall or flush, otherwise ALU or MD result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_reg_waddr <= '0;
      ex2mem_alu_out   <= '0;
      ex2mem_ill_instr <= 1'b0;
    end else if (ex_flush || ex_stall) begin
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_ill_instr <= 1'b0;
    end else if (id2ex_md_req) begin
`ifdef VERIRISCV_MULDIV_EN
      ex2mem_reg_wen   <= id2ex_reg_wen;
      ex2mem_reg_waddr <= id2ex_reg_waddr;
      ex2mem_alu_out   <= md_result;
      ex2mem_ill_instr <= id2ex_ill_instr;
`else
      ex2mem_reg_wen   <= 1'b0;
      ex2mem_reg_waddr <= id2ex_reg_waddr;
      ex2mem_alu_out   <= '0;
      ex2mem_ill_instr <= 1'b1;
`endif
    end else begin
      ex2mem_reg_wen   <= id2ex_reg_wen;
      ex2mem_reg_waddr <= id2ex_reg_waddr;
      ex2mem_alu_out   <= alu_res;
      ex2mem_ill_instr <= id2ex_ill_instr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed and randomized ALU/MD operations checked
// against an arithmetic reference model. Handles both VERIRISCV_MULDIV_EN builds.
`timescale 1ns/1ps
module tb_ex_stage;
  localparam int XLEN = 32;
  localparam int IMM_WIDTH = 20;
  localparam int RF_AW = 5;
  localparam int ALU_OP_W = 4;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9;
  localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
                         MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;

  logic        clk, rst_n;
  logic        id2ex_reg_wen;
  logic [4:0]  id2ex_reg_waddr;
  logic [31:0] id2ex_reg_rs1_data, id2ex_reg_rs2_data;
  logic [19:0] id2ex_imm_value;
  logic [3:0]  id2ex_alu_op;
  logic        id2ex_sel_imm;
  logic        id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb;
  logic        id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb;
  logic        id2ex_ill_instr, id2ex_md_req;
  logic [2:0]  id2ex_md_op;
  logic [31:0] wb_reg_wdata;
  logic        ex_flush;
  logic        ex_stall, ex2mem_reg_wen, ex2mem_ill_instr;
  logic [4:0]  ex2mem_reg_waddr;
  logic [31:0] ex2mem_alu_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_mem;   // what the model says ex2mem_alu_out holds

  ex_stage #(.XLEN(XLEN), .IMM_WIDTH(IMM_WIDTH), .RF_AW(RF_AW), .ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id2ex_reg_wen(id2ex_reg_wen), .id2ex_reg_waddr(id2ex_reg_waddr),
    .id2ex_reg_rs1_data(id2ex_reg_rs1_data), .id2ex_reg_rs2_data(id2ex_reg_rs2_data),
    .id2ex_imm_value(id2ex_imm_value), .id2ex_alu_op(id2ex_alu_op), .id2ex_sel_imm(id2ex_sel_imm),
    .id2ex_rs1_forward_from_mem(id2ex_rs1_forward_from_mem),
    .id2ex_rs1_forward_from_wb(id2ex_rs1_forward_from_wb),
    .id2ex_rs2_forward_from_mem(id2ex_rs2_forward_from_mem),
    .id2ex_rs2_forward_from_wb(id2ex_rs2_forward_from_wb),
    .id2ex_ill_instr(id2ex_ill_instr), .id2ex_md_req(id2ex_md_req), .id2ex_md_op(id2ex_md_op),
    .wb_reg_wdata(wb_reg_wdata), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex2mem_reg_wen(ex2mem_reg_wen), .ex2mem_reg_waddr(ex2mem_reg_waddr),
    .ex2mem_alu_out(ex2mem_alu_out), .ex2mem_ill_instr(ex2mem_ill_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  return a ^ b;
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return sa >>> b[4:0];
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      MD_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      MD_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : ia / ib);
      MD_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MD_REM:    return (b == 32'd0) ? a : (ovf ? 32'd0 : ia % ib);
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic sel, input logic [19:0] imm,
                         input logic f1m, input logic f1w, input logic f2m, input logic f2w,
                         input logic [31:0] wbd);
    logic [31:0] a, b, exp;
    logic wen;
    logic [4:0] wa;
    a = f1m ? model_mem : (f1w ? wbd : rs1);
    b = f2m ? model_mem : (f2w ? wbd : rs2);
    if (sel) b = {{12{imm[19]}}, imm};
    exp = alu_ref(op, a, b);
    wen = 1'($urandom_range(0, 1));
    wa = 5'($urandom_range(1, 31));
    id2ex_md_req = 1'b0; id2ex_alu_op = op; id2ex_reg_rs1_data = rs1; id2ex_reg_rs2_data = rs2;
    id2ex_sel_imm = sel; id2ex_imm_value = imm; id2ex_rs1_forward_from_mem = f1m;
    id2ex_rs1_forward_from_wb = f1w; id2ex_rs2_forward_from_mem = f2m;
    id2ex_rs2_forward_from_wb = f2w; wb_reg_wdata = wbd; id2ex_reg_wen = wen;
    id2ex_reg_waddr = wa; id2ex_ill_instr = 1'b0;
    #1;
    check({tag, "_stall"}, 64'(ex_stall), 64'd0);
    @(negedge clk);
    check({tag, "_out"}, 64'(ex2mem_alu_out), 64'(exp));
    check({tag, "_wen"}, 64'(ex2mem_reg_wen), 64'(wen));
    check({tag, "_waddr"}, 64'(ex2mem_reg_waddr), 64'(wa));
    model_mem = exp;
  endtask

  task automatic start_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa);
    id2ex_md_req = 1'b1; id2ex_md_op = op; id2ex_alu_op = 4'($urandom_range(0, 9));
    id2ex_reg_wen = 1'b1; id2ex_reg_waddr = wa; id2ex_sel_imm = 1'b0; id2ex_ill_instr = 1'b0;
    id2ex_imm_value = 20'($urandom); id2ex_rs1_forward_from_mem = 1'b0;
    id2ex_rs2_forward_from_mem = 1'b0; id2ex_rs2_forward_from_wb = 1'b0;
    id2ex_reg_rs2_data = b;
    if ($urandom_range(0, 1) == 1) begin
      id2ex_reg_rs1_data = $urandom; id2ex_rs1_forward_from_wb = 1'b1; wb_reg_wdata = a;
    end else begin
      id2ex_reg_rs1_data = a; id2ex_rs1_forward_from_wb = 1'b0; wb_reg_wdata = $urandom;
    end
  endtask

  // counts stall cycles (bounded), scrambling operand sources after the accept cycle
  task automatic wait_stall(input string tag, output int n);
    n = 0;
    #1;
    while (ex_stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      id2ex_reg_rs1_data = $urandom; id2ex_reg_rs2_data = $urandom; wb_reg_wdata = $urandom;
      id2ex_rs1_forward_from_wb = 1'($urandom_range(0, 1));
      id2ex_rs2_forward_from_mem = 1'($urandom_range(0, 1));
      #1;
      if (n == 2) check({tag, "_bubble_wen"}, 64'(ex2mem_reg_wen), 64'd0);
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    logic [4:0] wa;
    int n;
    exp = md_ref(op, a, b);
    wa = 5'($urandom_range(1, 31));
    start_md(op, a, b, wa);
`ifdef VERIRISCV_MULDIV_EN
    wait_stall(tag, n);
    check({tag, "_stall_cycles"}, 64'(n), 64'(XLEN + 1));
    @(negedge clk);
    check({tag, "_out"}, 64'(ex2mem_alu_out), 64'(exp));
    check({tag, "_wen"}, 64'(ex2mem_reg_wen), 64'd1);
    check({tag, "_waddr"}, 64'(ex2mem_reg_waddr), 64'(wa));
    model_mem = exp;
`else
    #1;
    check({tag, "_nostall"}, 64'(ex_stall), 64'd0);
    @(negedge clk);
    check({tag, "_ill"}, 64'(ex2mem_ill_instr), 64'd1);
    check({tag, "_wen"}, 64'(ex2mem_reg_wen), 64'd0);
    check({tag, "_out"}, 64'(ex2mem_alu_out), 64'd0);
    model_mem = 32'd0;
`endif
    id2ex_md_req = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    // reset state, with an MD request pending to show the stall is held low
    rst_n = 1'b0; ex_flush = 1'b0; id2ex_md_req = 1'b1; id2ex_md_op = MD_DIV;
    id2ex_reg_wen = 1'b1; id2ex_reg_waddr = 5'd7; id2ex_reg_rs1_data = 32'd0;
    id2ex_reg_rs2_data = 32'd0; id2ex_imm_value = 20'd0; id2ex_alu_op = OP_ADD;
    id2ex_sel_imm = 1'b0; id2ex_rs1_forward_from_mem = 1'b0; id2ex_rs1_forward_from_wb = 1'b0;
    id2ex_rs2_forward_from_mem = 1'b0; id2ex_rs2_forward_from_wb = 1'b0;
    id2ex_ill_instr = 1'b1; wb_reg_wdata = 32'd0; model_mem = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_wen", 64'(ex2mem_reg_wen), 64'd0);
    check("rst_ill", 64'(ex2mem_ill_instr), 64'd0);
    check("rst_waddr", 64'(ex2mem_reg_waddr), 64'd0);
    check("rst_out", 64'(ex2mem_alu_out), 64'd0);
    check("rst_stall", 64'(ex_stall), 64'd0);
    id2ex_md_req = 1'b0; id2ex_ill_instr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI with a negative immediate
    run_alu("addi", OP_ADD, 32'd5, 32'd0, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("addi_const", 64'(ex2mem_alu_out), 64'd4);
    // MEM forwarding wins over WB
    run_alu("add7", OP_ADD, 32'd3, 32'd4, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_alu("fwd_prio", OP_ADD, 32'hDEAD, 32'd1, 1'b0, 20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9);
    check("fwd_prio_const", 64'(ex2mem_alu_out), 64'd8);

    for (int i = 0; i < 24; i++) begin
      run_alu("alu_rand", 4'($urandom_range(0, 9)), $urandom, $urandom, 1'($urandom_range(0, 1)),
              20'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // flush kills an illegal ALU instruction
    id2ex_alu_op = OP_OR; id2ex_reg_wen = 1'b1; id2ex_ill_instr = 1'b1; ex_flush = 1'b1;
    @(negedge clk);
    check("flush_alu_wen", 64'(ex2mem_reg_wen), 64'd0);
    check("flush_alu_ill", 64'(ex2mem_ill_instr), 64'd0);
    ex_flush = 1'b0; id2ex_ill_instr = 1'b0;

    // directed MD cases, issued back to back
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef VERIRISCV_MULDIV_EN
    check("mulhu_const", 64'(ex2mem_alu_out), 64'hFFFF_FFFE);
`endif
    run_md("mul", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef VERIRISCV_MULDIV_EN
    check("mul_const", 64'(ex2mem_alu_out), 64'd1);
`endif
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divu_z", MD_DIVU, 32'd1234, 32'd0);
    run_md("remu_z", MD_REMU, 32'd13, 32'd0);
`ifdef VERIRISCV_MULDIV_EN
    check("remu_z_const", 64'(ex2mem_alu_out), 64'd13);
`endif
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2);
    run_md("div_z", MD_DIV, 32'hFFFF_FFF9, 32'd0);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    run_md("mulh", MD_MULH, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = rb >> $urandom_range(8, 30);
        default: rb = rb;
      endcase
      run_md("md_rand", 3'($urandom_range(0, 7)), ra, rb);
    end

`ifdef VERIRISCV_MULDIV_EN
    // flush in BUSY cycle 10
    start_md(MD_MUL, $urandom, $urandom, 5'd3);
    repeat (10) @(negedge clk);
    ex_flush = 1'b1;
    #1;
    check("flush_busy_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    check("flush_busy_wen", 64'(ex2mem_reg_wen), 64'd0);
    ex_flush = 1'b0; id2ex_md_req = 1'b0;
    run_alu("after_flush", OP_ADD, 32'd100, 32'd23, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run_md("md_after_flush", MD_DIVU, 32'd1000, 32'd7);

    // flush coinciding with DONE drops the result
    start_md(MD_REMU, 32'd100, 32'd7, 5'd9);
    wait_stall("flush_done", n);
    ex_flush = 1'b1;
    @(negedge clk);
    check("flush_done_wen", 64'(ex2mem_reg_wen), 64'd0);
    ex_flush = 1'b0; id2ex_md_req = 1'b0;
`endif

    // reset in the middle of an MD op
    run_alu("pre_rst", OP_ADD, 32'd1, 32'd2, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    start_md(MD_DIV, 32'd77, 32'd5, 5'd11);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_wen", 64'(ex2mem_reg_wen), 64'd0);
    check("midrst_ill", 64'(ex2mem_ill_instr), 64'd0);
    check("midrst_waddr", 64'(ex2mem_reg_waddr), 64'd0);
    check("midrst_out", 64'(ex2mem_alu_out), 64'd0);
    check("midrst_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    id2ex_md_req = 1'b0;
    rst_n = 1'b1;
    model_mem = 32'd0;
    run_md("post_rst", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_alu("post_rst_alu", OP_SUB, 32'd10, 32'd3, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
